// File: rtl/qadd_pkg.sv
// Shared definitions for the qadd/qsub datapath family: common width and
// the record carried by each pipeline stage.
package qadd_pkg;

  localparam int SIZE = 8;
  localparam int QSUB_DEPTH = 3;

  typedef struct packed {
    logic            valid;
    logic [SIZE-1:0] data;
    logic [SIZE-1:0] b;
    logic [SIZE-1:0] c;
  } pipe_stage_t;

endpackage

// File: rtl/qsub_pp_stage.sv
// One qsub pipeline register: captures valid/data/b/c on enable, optionally
// subtracting b from data on the way in (modulo 2^WIDTH).
module qsub_stage
  import qadd_pkg::*;
#(
  parameter int WIDTH  = SIZE,
  parameter bit SUB_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] c_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c_q;

  always_comb begin
    data_d = data_i;
    if (SUB_EN) begin
      data_d = data_i - b_i;
    end
  end

  // Data fields load regardless of valid_i; only the valid bit is meaningful.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      b_q     <= b_i;
      c_q     <= c_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign b_o     = b_q;
  assign c_o     = c_q;

endmodule

// File: rtl/qsub_pp.sv
// Pipelined qadd decoder: a = c - b - b over three stages with a global
// stall, plus an ok flag re-encoding a + b + b against the original c.
module qsub_pp
  import qadd_pkg::*;
#(
  parameter int WIDTH  = SIZE,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic             ok,
  output logic [1:0]       busy
);

  if (STAGES != QSUB_DEPTH) begin : g_bad_stages
    $error("qsub_pp: STAGES must be 3");
  end

  logic             adv;
  logic             vld_p1, vld_p2, vld_p3;
  logic [WIDTH-1:0] d_p1, d_p2, d_p3;
  logic [WIDTH-1:0] b_p1, b_p2, b_p3;
  logic [WIDTH-1:0] c_p1, c_p2, c_p3;
  logic [WIDTH-1:0] chk_sum;
  logic             acc_in, acc_out;
  logic [1:0]       busy_q, busy_d;

  // Global stall: the whole pipe moves only when the last slot can drain.
  assign adv      = !vld_p3 || out_ready;
  assign in_ready = adv;

  qsub_stage #(.WIDTH(WIDTH), .SUB_EN(1'b0)) u_s1 (
    .clk     (clk),
    .rst_n   (rst),
    .en_i    (adv),
    .valid_i (in_valid),
    .data_i  (c),
    .b_i     (b),
    .c_i     (c),
    .valid_o (vld_p1),
    .data_o  (d_p1),
    .b_o     (b_p1),
    .c_o     (c_p1)
  );

  qsub_stage #(.WIDTH(WIDTH), .SUB_EN(1'b1)) u_s2 (
    .clk     (clk),
    .rst_n   (rst),
    .en_i    (adv),
    .valid_i (vld_p1),
    .data_i  (d_p1),
    .b_i     (b_p1),
    .c_i     (c_p1),
    .valid_o (vld_p2),
    .data_o  (d_p2),
    .b_o     (b_p2),
    .c_o     (c_p2)
  );

  qsub_stage #(.WIDTH(WIDTH), .SUB_EN(1'b1)) u_s3 (
    .clk     (clk),
    .rst_n   (rst),
    .en_i    (adv),
    .valid_i (vld_p2),
    .data_i  (d_p2),
    .b_i     (b_p2),
    .c_i     (c_p2),
    .valid_o (vld_p3),
    .data_o  (d_p3),
    .b_o     (b_p3),
    .c_o     (c_p3)
  );

  assign chk_sum   = d_p3 + b_p3 + b_p3;
  assign a         = d_p3;
  assign out_valid = vld_p3;
  assign ok        = vld_p3 && (chk_sum == c_p3);

  // Occupancy tracks accepted-in minus accepted-out, so it equals v1+v2+v3.
  assign acc_in  = in_valid && adv;
  assign acc_out = vld_p3 && out_ready;

  always_comb begin
    busy_d = busy_q;
    if (acc_in && !acc_out) begin
      busy_d = busy_q + 2'd1;
    end else if (!acc_in && acc_out) begin
      busy_d = busy_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 2'd0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_qsub_pp.sv
// Directed plus randomized bench for qsub_pp against a slot-level model of
// the three-deep, globally stalled pipeline.
module tb_qsub_pp;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] c;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] a;
  logic       ok;
  logic [1:0] busy;

  int n_vec;
  int n_err;
  int slot[3];
  logic [7:0] hold_a;

  qsub_pp #(.WIDTH(8), .STAGES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c         (c),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .ok        (ok),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] r8();
    return 8'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++) slot[k] = -1;
  endtask

  // Drive one cycle of inputs, compare outputs with the model, then advance
  // the model by the rising edge that follows.
  task automatic step(input logic iv, input logic [7:0] cc, input logic [7:0] bb, input logic orr);
    logic ov;
    logic ir;
    int   cnt;
    @(negedge clk);
    in_valid  = iv;
    c         = cc;
    b         = bb;
    out_ready = orr;
    #1;
    ov  = (slot[2] >= 0);
    ir  = !ov || orr;
    cnt = 0;
    for (int k = 0; k < 3; k++) if (slot[k] >= 0) cnt++;
    chk("in_ready", in_ready, ir);
    chk("out_valid", out_valid, ov);
    chk("busy", busy, cnt);
    chk("ok", ok, ov);
    if (ov) chk("a", a, slot[2]);
    if (ir) begin
      slot[2] = slot[1];
      slot[1] = slot[0];
      slot[0] = iv ? ((int'(cc) - 2 * int'(bb)) & 255) : -1;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clear_model();
    rst = 1'b0;
    in_valid = 1'b0;
    c = '0;
    b = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_a", a, 0);
    chk("rst_ok", ok, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;

    // basic decode
    step(1, 8'h20, 8'h05, 1);
    step(0, 8'h00, 8'h00, 1);
    step(0, 8'h00, 8'h00, 1);
    step(0, 8'h00, 8'h00, 1);
    chk("basic_ov", out_valid, 1);
    chk("basic_a", a, 8'h16);
    chk("basic_ok", ok, 1);
    step(0, 8'h00, 8'h00, 1);
    chk("basic_busy", busy, 0);

    // wrap-around
    step(1, 8'h03, 8'h02, 1);
    step(1, 8'h00, 8'h80, 1);
    step(0, 8'h00, 8'h00, 1);
    step(0, 8'h00, 8'h00, 1);
    chk("wrap1_a", a, 8'hFF);
    chk("wrap1_ok", ok, 1);
    step(0, 8'h00, 8'h00, 1);
    chk("wrap2_a", a, 8'h00);
    chk("wrap2_ok", ok, 1);
    step(0, 8'h00, 8'h00, 1);

    // streaming
    for (int i = 0; i < 10; i++) begin
      step(1, 8'(i * 3 + 1), 8'(i), 1);
      chk("stream_in_ready", in_ready, 1);
      if (i >= 3) chk("stream_a", a, i - 2);
    end
    for (int j = 0; j < 3; j++) begin
      step(0, 8'h00, 8'h00, 1);
      chk("stream_tail_a", a, 8 + j);
    end
    step(0, 8'h00, 8'h00, 1);

    // backpressure
    for (int i = 0; i < 4; i++) step(1, r8(), r8(), 0);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_busy", busy, 3);
    hold_a = a;
    step(1, r8(), r8(), 0);
    chk("bp_hold_a", a, hold_a);
    chk("bp_hold_ok", ok, 1);
    step(1, r8(), r8(), 1);
    chk("bp_release_ir", in_ready, 1);
    chk("bp_release_ov", out_valid, 1);
    step(0, 8'h00, 8'h00, 0);
    chk("bp_after_busy", busy, 3);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 8'h00, 1);

    // reset mid-flight
    step(1, r8(), r8(), 1);
    step(1, r8(), r8(), 1);
    step(0, 8'h00, 8'h00, 1);
    step(0, 8'h00, 8'h00, 0);
    chk("pre_rst_busy", busy, 2);
    chk("pre_rst_ov", out_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_ov", out_valid, 0);
    chk("midrst_ok", ok, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ir", in_ready, 1);
    clear_model();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 8'h00, 8'h00, 1);
    step(1, 8'h40, 8'h10, 1);
    step(0, 8'h00, 8'h00, 1);
    step(0, 8'h00, 8'h00, 1);
    step(0, 8'h00, 8'h00, 1);
    chk("postrst_ov", out_valid, 1);
    chk("postrst_a", a, 8'h20);

    // self-check negative
    step(1, 8'h20, 8'h05, 0);
    step(0, 8'h00, 8'h00, 0);
    step(0, 8'h00, 8'h00, 0);
    step(0, 8'h00, 8'h00, 0);
    force dut.d_p3 = 8'h00;
    #1;
    chk("neg_ov", out_valid, 1);
    chk("neg_a", a, 8'h00);
    chk("neg_ok", ok, 0);
    release dut.d_p3;
    #1;
    chk("neg_restore_ok", ok, 1);
    step(0, 8'h00, 8'h00, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), r8(), r8(), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) step(0, 8'h00, 8'h00, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/qsub_pp.md
Name: qsub_pp

Overview:
- Pipelined inverse of the qadd datapath: recovers operand a from a sum c and step b, a = c - b - b (mod 2^WIDTH).
- Three register stages with a valid/ready handshake on both sides and a global stall.
- Sits downstream of qadd to decode its result, and doubles as a self-check: ok confirms a + b + b == c.

Parameters:
- WIDTH, 8, datapath width of a, b, c.
- STAGES, 3, pipeline depth. Fixed; any other value is rejected at elaboration.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  c/b presented this cycle (replaces qadd's "start" semantics).
- in_ready  output  1  pipeline can accept this cycle.
- c  input  WIDTH  encoded sum.
- b  input  WIDTH  step operand.
- out_valid  output  1  a/ok valid.
- out_ready  input  1  consumer accepts.
- a  output  WIDTH  decoded operand.
- ok  output  1  a + b + b == c for the presented result.
- busy  output  2  number of valid entries in the pipeline (0..3).

Behaviour:
Reset
- rst low clears all stage valid bits, data, b, and c registers, immediately and asynchronously.
- Reset values: in_ready=1, out_valid=0, a=0, ok=0, busy=0.
- Reset release is sampled synchronously: the first capture happens on the first rising edge with rst high.

Advance
- adv = !v3 || out_ready.
- in_ready = adv, a combinational function of v3 and out_ready only.
- No path exists from in_valid to in_ready.

Stages (all update only when adv=1; otherwise every stage holds)
- S1: v1 <= in_valid; d1 <= c; b1 <= b; c1 <= c.
- S2: v2 <= v1; d2 <= d1 - b1; b2 <= b1; c2 <= c1.
- S3: v3 <= v2; d3 <= d2 - b2; b3 <= b2; c3 <= c2.
- Data registers load even when the matching valid bit is 0. Only the valid bits are qualified.

Outputs
- a = d3; out_valid = v3.
- ok = v3 && ((d3 + b3 + b3) mod 2^WIDTH == c3). Computed combinationally from stage-3 registers; ok=0 whenever out_valid=0.

Latency and throughput
- Latency is exactly 3 cycles from an accepted input to out_valid, when no stall occurs.
- Throughput is 1 result per cycle while out_ready=1.

Arithmetic
- All subtraction is unsigned and wraps modulo 2^WIDTH. No carry or borrow output.

Stall
- When out_ready=0 and v3=1, the whole pipe freezes and in_ready=0.
- Bubbles are not compressed under stall; the design uses a simple global stall.
- The held a/ok value must stay stable until the handshake completes.

Simultaneous events
- Output handshake and input handshake in the same cycle: both complete and the pipe shifts.

busy counter
- Updates each cycle: +1 on input accept, -1 on output accept, unchanged if both or neither happen.
- Must always equal v1+v2+v3.

Reset mid-operation
- All in-flight results are discarded. No output handshake occurs for them.

Decomposition:
- Shared package qadd_pkg holds SIZE (=8) as the common width constant, used as the WIDTH default.
- qadd_pkg also holds a pipe_stage_t struct {valid, data, b, c}.
- One sub-module is natural: qsub_stage. It contains one pipeline register with enable plus a subtract-b option, and is instanced 3 times, with the subtract disabled in S1.

Test Plan:
- Basic decode: reset, then in_valid=1 with c=0x20, b=0x05 for 1 cycle, out_ready=1 -> out_valid high exactly 3 cycles later, a=0x16, ok=1, busy returns to 0.
- Wrap-around: c=0x03, b=0x02 -> a=0xFF, ok=1. Also c=0x00, b=0x80 -> a=0x00, ok=1.
- Streaming: 10 back-to-back inputs with c=i*3+1, b=i -> 10 consecutive out_valid cycles with a=(i+1) mod 256 each, in order, and in_ready held at 1 throughout.
- Backpressure: out_ready=0 while streaming -> after 3 accepts in_ready=0, busy=3, a/ok stable. Then out_ready=1 for 1 cycle -> exactly one result transfers and one new input is accepted in the same cycle.
- Reset mid-flight: drive rst low asynchronously (between clock edges) with busy=2 -> out_valid, ok and busy drop immediately. After release, no stale result appears and the next input returns after 3 cycles.
- Self-check negative: force d3 corruption via a bench hierarchical deposit of a=0x00 for c=0x20, b=0x05 -> ok=0 while out_valid=1.
